// File: rtl/asrv32_fetch_pkg.sv
// Shared definitions for the ASRV32 fetch stage: NOP encoding, fetch FSM
// state type and a PC increment helper.
package asrv32_fetch_pkg;

    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam int          FETCH_STATE_W = 2;

    typedef enum logic [FETCH_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // Next sequential PC; wraps modulo 2^32 with no flag.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/asrv32_fetch_skid.sv
// One-entry {inst, pc} skid buffer. Clear wins over load, load over unload.
module asrv32_fetch_skid
    import asrv32_fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_full
);

    logic        r_full;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    // Capture a response that decode could not take; release on unload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_inst <= NOP;
            r_pc   <= 32'h0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_inst <= i_inst;
            r_pc   <= i_pc;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_inst = r_inst;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule

// File: rtl/asrv32_fetch.sv
// ASRV32 instruction-fetch stage. Single outstanding memory request, one-entry
// skid for downstream stalls, redirect with in-flight response discard.
// Optional build macro: ASRV32_FETCH_MISALIGN_CHECK_EN adds
// o_exception_misaligned and turns misaligned redirect targets into an
// exception slot instead of a memory request.
module asrv32_fetch
    import asrv32_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_stb_inst,
    output logic [31:0] o_iaddr,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_change_pc,
    input  logic [31:0] i_next_pc
`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
    ,
    output logic        o_exception_misaligned
`endif
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_iaddr, w_iaddr_nxt;
    logic         r_ce, w_ce_nxt;
    logic [31:0]  r_inst, w_inst_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_redir, w_redir_nxt;
    logic         r_exc, w_exc_nxt;

    logic         w_stb;
    logic [31:0]  w_tgt;
    logic         w_tgt_mis;
    logic         w_redir_mis;
    logic         w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
    logic [31:0]  w_skid_inst, w_skid_pc;

`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
    assign w_tgt       = i_next_pc;
    assign w_tgt_mis   = |i_next_pc[1:0];
    assign w_redir_mis = |r_redir[1:0];
    assign o_exception_misaligned = r_exc;
`else
    logic w_unused_lsb;
    assign w_tgt        = {i_next_pc[31:2], 2'b00};
    assign w_tgt_mis    = 1'b0;
    assign w_redir_mis  = 1'b0;
    assign w_unused_lsb = ^i_next_pc[1:0];
`endif

    // DRAIN keeps the original request up until its response arrives.
    assign w_stb = (r_state == S_FETCH) || (r_state == S_DRAIN);

    asrv32_fetch_skid u_skid (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_inst   (i_inst),
        .i_pc     (r_iaddr),
        .o_inst   (w_skid_inst),
        .o_pc     (w_skid_pc),
        .o_full   (w_skid_full)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iaddr <= PC_RESET;
            r_ce    <= 1'b0;
            r_inst  <= NOP;
            r_pc    <= PC_RESET;
            r_redir <= PC_RESET;
            r_exc   <= 1'b0;
        end else begin
            r_iaddr <= w_iaddr_nxt;
            r_ce    <= w_ce_nxt;
            r_inst  <= w_inst_nxt;
            r_pc    <= w_pc_nxt;
            r_redir <= w_redir_nxt;
            r_exc   <= w_exc_nxt;
        end
    end

    // Next-state and datapath update; change beats flush beats stall.
    always_comb begin
        w_state_nxt   = r_state;
        w_iaddr_nxt   = r_iaddr;
        w_ce_nxt      = r_ce;
        w_inst_nxt    = r_inst;
        w_pc_nxt      = r_pc;
        w_redir_nxt   = r_redir;
        w_exc_nxt     = r_exc;
        w_skid_load   = 1'b0;
        w_skid_unload = 1'b0;
        w_skid_clear  = 1'b0;

        if (i_change_pc) begin
            w_ce_nxt     = 1'b0;
            w_skid_clear = 1'b1;
            w_exc_nxt    = 1'b0;
            if (w_stb && !i_ack_inst) begin
                // Request still in flight: park the target until it lands.
                w_redir_nxt = w_tgt;
                w_state_nxt = S_DRAIN;
            end else if (w_tgt_mis) begin
                w_state_nxt = S_HOLD;
                w_exc_nxt   = 1'b1;
                w_ce_nxt    = 1'b1;
                w_inst_nxt  = NOP;
                w_pc_nxt    = w_tgt;
            end else begin
                w_iaddr_nxt = w_tgt;
                w_state_nxt = S_FETCH;
            end
        end else begin
            if (i_flush) begin
                w_ce_nxt     = 1'b0;
                w_skid_clear = 1'b1;
                w_exc_nxt    = 1'b0;
            end
            case (r_state)
                S_IDLE: w_state_nxt = S_FETCH;
                S_FETCH: begin
                    if (i_ack_inst) begin
                        w_iaddr_nxt = pc_inc(r_iaddr);
                        if (i_flush) begin
                            // Response completes the request but is dropped.
                        end else if (r_ce && i_stall) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_inst_nxt = i_inst;
                            w_pc_nxt   = r_iaddr;
                            w_ce_nxt   = 1'b1;
                        end
                    end else if (r_ce && !i_stall) begin
                        w_ce_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (i_flush) begin
                        w_state_nxt = S_FETCH;
                    end else if (!r_exc && w_skid_full && !i_stall) begin
                        w_inst_nxt    = w_skid_inst;
                        w_pc_nxt      = w_skid_pc;
                        w_ce_nxt      = 1'b1;
                        w_skid_unload = 1'b1;
                        w_state_nxt   = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (i_ack_inst) begin
                        if (w_redir_mis) begin
                            w_state_nxt = S_HOLD;
                            w_exc_nxt   = 1'b1;
                            w_ce_nxt    = 1'b1;
                            w_inst_nxt  = NOP;
                            w_pc_nxt    = r_redir;
                        end else begin
                            w_iaddr_nxt = r_redir;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign o_stb_inst = w_stb;
    assign o_iaddr    = r_iaddr;
    assign o_ce       = r_ce;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Scoreboard bench for asrv32_fetch: memory model returns addr^A5A5_0000,
// expected {inst, pc} pairs are queued by stimulus and popped by a monitor
// on each decode consumption.
module tb_asrv32_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [31:0] iaddr;
    logic        ack;
    logic [31:0] mem_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ce;
    logic        stall;
    logic        flush;
    logic        change;
    logic [31:0] next_pc;
`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
    logic        exc;
`endif

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XMASK  = 32'hA5A5_0000;

    always #5 clk = ~clk;

    asrv32_fetch #(.PC_RESET(RST_PC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_stb_inst  (stb),
        .o_iaddr     (iaddr),
        .i_ack_inst  (ack),
        .i_inst      (mem_data),
        .o_inst      (inst),
        .o_pc        (pc),
        .o_ce        (ce),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_change_pc (change),
        .i_next_pc   (next_pc)
`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
        ,
        .o_exception_misaligned (exc)
`endif
    );

    // Memory with programmable wait states; ack is combinational once the
    // request has waited mem_wait cycles.
    logic        mem_en;
    int unsigned mem_wait;
    int unsigned mem_cnt;
    assign ack      = stb && mem_en && (mem_cnt >= mem_wait);
    assign mem_data = iaddr ^ XMASK;
    always @(posedge clk) begin
        if (rst || !stb || ack) mem_cnt <= 0;
        else                    mem_cnt <= mem_cnt + 1;
    end

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] p);
        exp_q.push_back('{inst: p ^ XMASK, pc: p});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decode consumes on o_ce && !i_stall unless the same cycle kills it.
    always @(negedge clk) begin
        if (!rst && ce && !stall && !change && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual pc=%h required=no output", pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_inst", inst, e.inst);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ce"}, {31'h0, ce}, 32'h0);
        chk({tag, "_stb"}, {31'h0, stb}, 32'h0);
        chk({tag, "_iaddr"}, iaddr, RST_PC);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_inst"}, inst, 32'h0000_0013);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        chk("rst_skid_empty", {31'h0, dut.u_skid.o_full}, 32'h0);
        rst = 1'b0;
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; change = 1'b0;
        next_pc = 32'h0; mem_en = 1'b1; mem_wait = 0;

        // Zero-wait streaming after reset.
        do_reset();
        push(32'h100); push(32'h104); push(32'h108);
        tick();
        chk("t1_stb_after_idle", {31'h0, stb}, 32'h1);
        chk("t1_ce_not_yet", {31'h0, ce}, 32'h0);
        tick();
        chk("t1_ce_rise", {31'h0, ce}, 32'h1);
        tick(); tick();
        mem_en = 1'b0;
        tick();
        chk("t1_ce_consumed", {31'h0, ce}, 32'h0);
        chk("t1_iaddr", iaddr, 32'h10C);
        chk_drained("t1_drained");

        // Stall absorbs an ack into the skid.
        mem_en = 1'b1;
        do_reset();
        push(32'h100); push(32'h104); push(32'h108);
        tick(); tick();
        stall = 1'b1;
        tick();
        chk("t2_stb_drop", {31'h0, stb}, 32'h0);
        chk("t2_pc_hold", pc, 32'h100);
        chk("t2_ce_hold", {31'h0, ce}, 32'h1);
        chk("t2_iaddr", iaddr, 32'h108);
        tick(); tick();
        chk("t2_pc_hold2", pc, 32'h100);
        stall = 1'b0;
        tick();
        chk("t2_pc_skid", pc, 32'h104);
        tick();
        chk("t2_pc_next", pc, 32'h108);
        mem_en = 1'b0;
        tick();
        chk("t2_ce_clear", {31'h0, ce}, 32'h0);
        chk_drained("t2_drained");

        // Redirect during a 3-wait-state request.
        mem_en = 1'b1; mem_wait = 3;
        do_reset();
        tick(); tick();
        change = 1'b1; next_pc = 32'h200;
        tick();
        change = 1'b0;
        chk("t3_drain_stb", {31'h0, stb}, 32'h1);
        chk("t3_drain_iaddr", iaddr, 32'h100);
        chk("t3_drain_ce", {31'h0, ce}, 32'h0);
        push(32'h200);
        tick(); tick();
        chk("t3_redir_iaddr", iaddr, 32'h200);
        for (int k = 0; k < 20 && !ce; k++) tick();
        chk("t3_ce_timeout", {31'h0, ce}, 32'h1);
        mem_en = 1'b0;
        tick();
        chk_drained("t3_drained");
        mem_wait = 0;

        // Redirect with a same-cycle ack (low bits dropped in base build).
        mem_en = 1'b1;
        do_reset();
        tick();
        change = 1'b1;
`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
        next_pc = 32'h300;
`else
        next_pc = 32'h303;
`endif
        tick();
        change = 1'b0;
        chk("t4_iaddr", iaddr, 32'h300);
        chk("t4_ce_drop", {31'h0, ce}, 32'h0);
        push(32'h300);
        tick();
        chk("t4_ce_rise", {31'h0, ce}, 32'h1);
        mem_en = 1'b0;
        tick();
        chk_drained("t4_drained");

        // Address wrap.
        mem_en = 1'b1;
        do_reset();
        tick();
        change = 1'b1; next_pc = 32'hFFFF_FFFC;
        tick();
        change = 1'b0;
        push(32'hFFFF_FFFC); push(32'h0);
        tick();
        chk("t5_wrap_iaddr", iaddr, 32'h0);
        tick();
        mem_en = 1'b0;
        tick();
        chk_drained("t5_drained");

        // Flush kills valid output and same-cycle ack data.
        mem_en = 1'b1;
        do_reset();
        push(32'h100);
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_en = 1'b0;
        chk("t6_flush_ce", {31'h0, ce}, 32'h0);
        chk("t6_flush_iaddr", iaddr, 32'h10C);
        tick();
        chk_drained("t6_drained");

        // Reset while holding a skid entry.
        mem_en = 1'b1;
        do_reset();
        tick(); tick();
        stall = 1'b1;
        tick();
        chk("t7_skid_full", {31'h0, dut.u_skid.o_full}, 32'h1);
        rst = 1'b1;
        tick();
        chk_reset("t7");
        chk("t7_skid_empty", {31'h0, dut.u_skid.o_full}, 32'h0);
        stall = 1'b0;
        mem_en = 1'b0;
        tick();
        chk_drained("t7_drained");

`ifdef ASRV32_FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect presents an exception slot, no request.
        mem_en = 1'b1;
        do_reset();
        tick();
        stall = 1'b1;
        change = 1'b1; next_pc = 32'h202;
        tick();
        change = 1'b0;
        chk("t8_stb", {31'h0, stb}, 32'h0);
        chk("t8_ce", {31'h0, ce}, 32'h1);
        chk("t8_pc", pc, 32'h202);
        chk("t8_exc", {31'h0, exc}, 32'h1);
        tick(); tick();
        chk("t8_exc_hold", {31'h0, exc}, 32'h1);
        change = 1'b1; next_pc = 32'h400;
        tick();
        change = 1'b0;
        chk("t8_exc_clear", {31'h0, exc}, 32'h0);
        chk("t8_iaddr", iaddr, 32'h400);
        chk("t8_stb_back", {31'h0, stb}, 32'h1);
        mem_en = 1'b0;
        stall = 1'b0;
        tick();
        chk_drained("t8_drained");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
